pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the MIPS-style CPU core. It selects the next PC from exception, exception-return, branch, register-jump, absolute-jump and sequential sources under a fixed priority, and honours a pipeline stall. It captures the EPC and keeps a circular return-address stack (RAS) that predicts jal/jr $31 returns. It sits at the head of the fetch path and drives the instruction-memory address.

Parameters:
WIDTH, 32, PC/address width in bits (must be >= 28)
RESET_VEC, 32'h0000_3000, PC value loaded on reset
EXC_VEC, 32'h0000_4180, PC value loaded on exception entry
RAS_DEPTH, 4, number of RAS entries (power of two, >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  hold PC; masks every source except exc
exc  in  1  exception request
exc_pc  in  WIDTH  PC of faulting instruction, captured into epc
eret  in  1  return from exception
br_taken  in  1  resolved taken branch
br_target  in  WIDTH  branch target
jr  in  1  jump-register
jr_target  in  WIDTH  register value for jr
jr_is_ra  in  1  jr source is $31 (qualifies RAS pop)
jump  in  1  j/jal absolute jump
jal  in  1  link (valid with jump); pushes return address
jump_idx  in  26  instr_index field
pc  out  WIDTH  current PC
pc_plus4  out  WIDTH  pc+4, combinational
epc  out  WIDTH  exception PC register
ras_top  out  WIDTH  predicted return address; 0 when empty
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_ovf  out  1  sticky: push while full
ras_unf  out  1  sticky: pop while empty

Behaviour:
- Reset (async): pc=RESET_VEC, epc=0, RAS count=0, pointer=0, ras_ovf=ras_unf=0; ras_empty=1, ras_full=0, ras_top=0.
- All updates occur on the rising clk edge; the new PC is visible 1 cycle after its source is asserted. No delay slot.
- Next-PC priority (highest first):
  1. exc: pc<=EXC_VEC, epc<=exc_pc; applies even when stall=1.
  2. stall: pc holds; no RAS change.
  3. eret: pc<=epc.
  4. br_taken: pc<=br_target.
  5. jr: pc<=jr_target.
  6. jump: pc<={pc[WIDTH-1:28], jump_idx, 2'b00}.
  7. otherwise: pc<=pc+4.
- Only the winning source has side effects; losing sources are ignored, not queued.
- Arithmetic is modulo 2^WIDTH; pc+4 wraps from all-ones-minus-3 to 0.
- RAS push happens when jump&&jal wins priority; the value pushed is pc+4 of the jal. Write goes to entry[ptr], then ptr<=ptr+1 mod RAS_DEPTH.
  - Count increments, saturating at RAS_DEPTH.
  - A push while full overwrites the oldest entry (circular wrap), keeps count=RAS_DEPTH and sets ras_ovf.
- RAS pop happens when jr&&jr_is_ra wins priority: ptr<=ptr-1 and count decrements.
  - A pop while empty leaves ptr and count unchanged and sets ras_unf.
  - pc still takes jr_target; the RAS is prediction only.
- ras_top = entry[ptr-1] when count>0, else 0. It is registered-state derived, with no combinational path from inputs.
- exc, eret, br_taken, and non-jal jumps do not modify the RAS.
- Sticky flags clear only on reset.
- Reset asserted mid-sequence (e.g. during a stall or right after a push) returns every output to its reset value immediately, with no clk edge needed.

Test Plan:
- Reset, then 3 free-running cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; pc_plus4 tracks pc+4; epc=0; ras_empty=1.
- At pc=0x3010, stall=1 for 2 cycles with br_taken=1, br_target=0x3400 -> pc stays 0x3010. Release stall with br_taken still 1 -> pc=0x3400 next cycle.
- At pc=0x3020, jump=jal=1, jump_idx=0x0000C40 -> pc=0x3100, ras_top=0x3024, ras_empty=0. Then jr=jr_is_ra=1, jr_target=0x3024 -> pc=0x3024, ras_empty=1, ras_top=0.
- RAS_DEPTH=4: five jal pushes with return addresses A1..A5 -> ras_full=1, ras_ovf=1, ras_top=A5. Four pops give A5, A4, A3, A2, then ras_empty=1. A fifth pop -> ras_unf=1, count stays 0.
- stall=1 with exc=1, exc_pc=0x3058 and br_taken=1 in the same cycle -> pc=0x4180, epc=0x3058, RAS unchanged. Next cycle eret=1 -> pc=0x3058.
- Assert rst asynchronously between clk edges after two pushes -> pc=0x3000, ras_empty=1, ras_ovf=0 immediately. Normal increment resumes after rst is deasserted.

Source files
------------

// File: rtl/pc_unit_if.sv
// Bus between the fetch-control logic and the program-counter unit.
// The master drives the next-PC requests; the slave (pc_unit) returns PC, EPC and RAS state.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             exc;
  logic [WIDTH-1:0] exc_pc;
  logic             eret;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jr;
  logic [WIDTH-1:0] jr_target;
  logic             jr_is_ra;
  logic             jump;
  logic             jal;
  logic [25:0]      jump_idx;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output stall, exc, exc_pc, eret, br_taken, br_target,
           jr, jr_target, jr_is_ra, jump, jal, jump_idx,
    input  pc, pc_plus4, epc, ras_top, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, exc, exc_pc, eret, br_taken, br_target,
           jr, jr_target, jr_is_ra, jump, jal, jump_idx,
    output pc, pc_plus4, epc, ras_top, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-PC selection, EPC capture and a
// circular return-address stack predicting jal / jr $31 pairs.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
  parameter int               RAS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  pc_unit_if.slave   bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_HOLD,
    SRC_ERET,
    SRC_BR,
    SRC_JR,
    SRC_JUMP,
    SRC_SEQ
  } src_e;

  src_e             src;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] jump_target;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;
  logic             ras_empty;
  logic             ras_full;
  logic             ovf_q;
  logic             unf_q;

  assign pc_plus4 = pc_q + WIDTH'(4);

  // Absolute jumps keep the upper segment bits of the current PC when there are any.
  if (WIDTH > 28) begin : g_seg
    assign jump_target = {pc_q[WIDTH-1:28], bus.jump_idx, 2'b00};
  end else begin : g_noseg
    assign jump_target = {bus.jump_idx, 2'b00};
  end

  always_comb begin
    src = SRC_SEQ;
    if (bus.exc)           src = SRC_EXC;
    else if (bus.stall)    src = SRC_HOLD;
    else if (bus.eret)     src = SRC_ERET;
    else if (bus.br_taken) src = SRC_BR;
    else if (bus.jr)       src = SRC_JR;
    else if (bus.jump)     src = SRC_JUMP;
  end

  // Only the winning source produces side effects on the RAS.
  always_comb begin
    pc_next = pc_plus4;
    push    = 1'b0;
    pop     = 1'b0;
    case (src)
      SRC_EXC:  pc_next = EXC_VEC;
      SRC_HOLD: pc_next = pc_q;
      SRC_ERET: pc_next = epc_q;
      SRC_BR:   pc_next = bus.br_target;
      SRC_JR: begin
        pc_next = bus.jr_target;
        pop     = bus.jr_is_ra;
      end
      SRC_JUMP: begin
        pc_next = jump_target;
        push    = bus.jal;
      end
      default:  pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
    end else begin
      pc_q <= pc_next;
      if (src == SRC_EXC) epc_q <= bus.exc_pc;
    end
  end

  assign ras_empty = (count == CW'(0));
  assign ras_full  = (count == CW'(RAS_DEPTH));

  // A push when full lands on the oldest slot, so the count saturates while ptr keeps wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (ras_full) ovf_q <= 1'b1;
      else          count <= count + CW'(1);
    end else if (pop) begin
      if (ras_empty) begin
        unf_q <= 1'b1;
      end else begin
        ptr   <= ptr - PW'(1);
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem[ptr] <= pc_plus4;
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.epc       = epc_q;
  assign bus.ras_top   = ras_empty ? '0 : ras_mem[ptr - PW'(1)];
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed plan steps followed by random
// traffic, all compared against a queue-based reference model.
module tb_pc_unit;
  localparam int          WIDTH     = 32;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_4180;

  logic clk = 1'b0;
  logic rst;

  pc_unit_if #(.WIDTH(WIDTH)) bus ();

  pc_unit #(
    .WIDTH(WIDTH), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the RAS is an ordered list of return addresses, newest last.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_ras[$];
  logic        m_ovf;
  logic        m_unf;

  task automatic modelReset();
    m_pc  = RESET_VEC;
    m_epc = 32'h0;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic modelStep();
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (bus.exc) begin
      m_pc  = EXC_VEC;
      m_epc = bus.exc_pc;
    end else if (bus.stall) begin
      m_pc = old_pc;
    end else if (bus.eret) begin
      m_pc = m_epc;
    end else if (bus.br_taken) begin
      m_pc = bus.br_target;
    end else if (bus.jr) begin
      m_pc = bus.jr_target;
      if (bus.jr_is_ra) begin
        if (m_ras.size() == 0) m_unf = 1'b1;
        else void'(m_ras.pop_back());
      end
    end else if (bus.jump) begin
      m_pc = {old_pc[31:28], bus.jump_idx, 2'b00};
      if (bus.jal) begin
        m_ras.push_back(old_pc + 32'd4);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
    end else begin
      m_pc = old_pc + 32'd4;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic checkAll(input string where);
    logic [31:0] exp_top;
    exp_top = (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
    checkOutput({where, ".pc"},        bus.pc,              m_pc);
    checkOutput({where, ".pc_plus4"},  bus.pc_plus4,        m_pc + 32'd4);
    checkOutput({where, ".epc"},       bus.epc,             m_epc);
    checkOutput({where, ".ras_top"},   bus.ras_top,         exp_top);
    checkOutput({where, ".ras_empty"}, 32'(bus.ras_empty),  32'(m_ras.size() == 0));
    checkOutput({where, ".ras_full"},  32'(bus.ras_full),   32'(m_ras.size() == DEPTH));
    checkOutput({where, ".ras_ovf"},   32'(bus.ras_ovf),    32'(m_ovf));
    checkOutput({where, ".ras_unf"},   32'(bus.ras_unf),    32'(m_unf));
  endtask

  task automatic setIdle();
    bus.stall     = 1'b0;
    bus.exc       = 1'b0;
    bus.exc_pc    = 32'h0;
    bus.eret      = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 32'h0;
    bus.jr        = 1'b0;
    bus.jr_target = 32'h0;
    bus.jr_is_ra  = 1'b0;
    bus.jump      = 1'b0;
    bus.jal       = 1'b0;
    bus.jump_idx  = 26'h0;
  endtask

  // One clock: predict from current inputs, clock the DUT, compare just after the edge.
  task automatic applyStimulus(input string where);
    modelStep();
    @(posedge clk);
    #1;
    checkAll(where);
  endtask

  initial begin
    setIdle();
    rst = 1'b1;
    modelReset();
    #2;
    checkAll("reset");
    #6 rst = 1'b0;

    $display("[TB] free-running increment");
    for (int i = 0; i < 3; i++) applyStimulus("seq");
    checkOutput("plan_seq_pc", bus.pc, 32'h300C);
    applyStimulus("seq4");

    $display("[TB] stall masks taken branch");
    bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h3400;
    applyStimulus("stall0");
    applyStimulus("stall1");
    checkOutput("plan_stall_pc", bus.pc, 32'h3010);
    bus.stall = 1'b0;
    applyStimulus("br");
    checkOutput("plan_br_pc", bus.pc, 32'h3400);

    $display("[TB] jal then jr $31");
    bus.br_target = 32'h3020;
    applyStimulus("br3020");
    setIdle();
    bus.jump = 1'b1; bus.jal = 1'b1; bus.jump_idx = 26'h0000C40;
    applyStimulus("jal");
    checkOutput("plan_jal_pc", bus.pc, 32'h3100);
    checkOutput("plan_jal_top", bus.ras_top, 32'h3024);
    setIdle();
    bus.jr = 1'b1; bus.jr_is_ra = 1'b1; bus.jr_target = 32'h3024;
    applyStimulus("jr_ra");
    checkOutput("plan_jr_pc", bus.pc, 32'h3024);

    $display("[TB] RAS overflow and underflow");
    for (int i = 0; i < 5; i++) begin
      setIdle();
      bus.jump = 1'b1; bus.jal = 1'b1; bus.jump_idx = 26'h0000C80 + 26'(i * 16);
      applyStimulus("push");
    end
    checkOutput("plan_ovf", 32'(bus.ras_ovf), 32'd1);
    for (int i = 0; i < 5; i++) begin
      setIdle();
      bus.jr = 1'b1; bus.jr_is_ra = 1'b1; bus.jr_target = 32'h3200 + 32'(i * 8);
      applyStimulus("pop");
    end
    checkOutput("plan_unf", 32'(bus.ras_unf), 32'd1);

    $display("[TB] exception beats stall and branch");
    setIdle();
    bus.stall = 1'b1; bus.exc = 1'b1; bus.exc_pc = 32'h3058;
    bus.br_taken = 1'b1; bus.br_target = 32'h3400;
    applyStimulus("exc");
    checkOutput("plan_exc_pc", bus.pc, 32'h4180);
    checkOutput("plan_exc_epc", bus.epc, 32'h3058);
    setIdle();
    bus.eret = 1'b1;
    applyStimulus("eret");
    checkOutput("plan_eret_pc", bus.pc, 32'h3058);

    $display("[TB] pc+4 wraparound");
    setIdle();
    bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFC;
    applyStimulus("br_top");
    setIdle();
    applyStimulus("wrap");
    checkOutput("plan_wrap_pc", bus.pc, 32'h0);

    $display("[TB] asynchronous reset after pushes");
    bus.jump = 1'b1; bus.jal = 1'b1; bus.jump_idx = 26'h0000D00;
    applyStimulus("push_a");
    bus.jump_idx = 26'h0000D40;
    applyStimulus("push_b");
    setIdle();
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkAll("async_rst");
    checkOutput("plan_rst_pc", bus.pc, 32'h3000);
    #2 rst = 1'b0;
    applyStimulus("post_rst");
    checkOutput("plan_post_rst_pc", bus.pc, 32'h3004);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      setIdle();
      bus.exc       = ($urandom_range(0, 29) == 0);
      bus.exc_pc    = $urandom;
      bus.stall     = ($urandom_range(0, 7) == 0);
      bus.eret      = ($urandom_range(0, 15) == 0);
      bus.br_taken  = ($urandom_range(0, 7) == 0);
      bus.br_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      bus.jr        = ($urandom_range(0, 4) == 0);
      bus.jr_is_ra  = ($urandom_range(0, 3) != 0);
      bus.jr_target = $urandom & 32'hFFFF_FFFC;
      bus.jump      = ($urandom_range(0, 3) == 0);
      bus.jal       = ($urandom_range(0, 2) != 0);
      bus.jump_idx  = 26'($urandom);
      applyStimulus("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
